// File: rtl/id_ex_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : id_ex_reg                                                  |
// | Brief   : ID/EX pipeline register with flush/stall bubbles, a        |
// |           saturating bubble counter and optional load-use detection  |
// |           (enabled by defining ID_EX_HAZARD_DETECT_EN).              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_ex_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [6:0]  ctrl_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  output logic [6:0]  ctrl_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [9:0]  funct_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        valid_o,
  output logic        hazard_stall_o,
  output logic [15:0] bubble_cnt_o
);

  // ctrl layout: {RegWrite, MemToReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
  localparam int          c_MEMREAD_BIT = 4;
  localparam logic [15:0] c_CNT_MAX     = 16'hFFFF;

  logic        r_valid;
  logic [6:0]  r_ctrl;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [9:0]  r_funct;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd_addr;
  logic [15:0] r_bubble_cnt;

  logic        w_hazard;
  logic        w_insert_bubble;
  logic [15:0] w_bubble_cnt_next;

`ifdef ID_EX_HAZARD_DETECT_EN
  // Load in EX whose destination feeds the instruction now in ID.
  assign w_hazard = r_valid & valid_i & r_ctrl[c_MEMREAD_BIT]
                  & (r_rd_addr != 5'd0)
                  & ((r_rd_addr == rs1_addr_i) | (r_rd_addr == rs2_addr_i));
`else
  assign w_hazard = 1'b0;
`endif

  // Flush beats stall; a hazard bubble only happens when nothing else acts.
  assign w_insert_bubble   = flush_i | (~stall_i & w_hazard);
  assign w_bubble_cnt_next = (r_bubble_cnt == c_CNT_MAX) ? r_bubble_cnt
                                                         : r_bubble_cnt + 16'd1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_funct      <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_bubble_cnt <= '0;
    end else if (w_insert_bubble) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_funct      <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_bubble_cnt <= w_bubble_cnt_next;
    end else if (!stall_i) begin
      r_valid      <= valid_i;
      r_ctrl       <= valid_i ? ctrl_i : 7'd0;
      r_rs1_data   <= rs1_data_i;
      r_rs2_data   <= rs2_data_i;
      r_imm        <= imm_i;
      r_funct      <= funct_i;
      r_rs1_addr   <= rs1_addr_i;
      r_rs2_addr   <= rs2_addr_i;
      r_rd_addr    <= rd_addr_i;
    end
  end

  assign valid_o        = r_valid;
  assign ctrl_o         = r_ctrl;
  assign rs1_data_o     = r_rs1_data;
  assign rs2_data_o     = r_rs2_data;
  assign imm_o          = r_imm;
  assign funct_o        = r_funct;
  assign rs1_addr_o     = r_rs1_addr;
  assign rs2_addr_o     = r_rs2_addr;
  assign rd_addr_o      = r_rd_addr;
  assign bubble_cnt_o   = r_bubble_cnt;
  assign hazard_stall_o = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_id_ex_reg                                               |
// | Brief   : Self-checking bench for id_ex_reg (directed + random vs.   |
// |           a behavioural model; honours ID_EX_HAZARD_DETECT_EN).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [6:0]  ctrl_i = '0;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
  logic [9:0]  funct_i = '0;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic [6:0]  ctrl_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        valid_o, hazard_stall_o;
  logic [15:0] bubble_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected pipeline-register contents
  logic        m_valid;
  logic [6:0]  m_ctrl;
  logic [31:0] m_rs1, m_rs2, m_imm;
  logic [9:0]  m_funct;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [15:0] m_cnt;

  id_ex_reg dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .ctrl_i(ctrl_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .ctrl_o(ctrl_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .funct_o(funct_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .valid_o(valid_o), .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic model_hazard();
`ifdef ID_EX_HAZARD_DETECT_EN
    return m_valid && valid_i && m_ctrl[4] && (m_rd != 0) && (m_rd == rs1_addr_i || m_rd == rs2_addr_i);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear(input logic keep_cnt);
    m_valid = 0; m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    m_funct = 0; m_a1 = 0; m_a2 = 0; m_rd = 0;
    if (!keep_cnt) m_cnt = 0;
  endtask

  // Advance one rising edge and apply the expected action to the model.
  task automatic cycle();
    logic bubble, load;
    bubble = flush_i || (!stall_i && model_hazard());
    load   = !flush_i && !stall_i && !bubble;
    @(posedge clk);
    #1;
    if (bubble) begin
      model_clear(1'b1);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end else if (load) begin
      m_valid = valid_i; m_ctrl = valid_i ? ctrl_i : 7'd0;
      m_rs1 = rs1_data_i; m_rs2 = rs2_data_i; m_imm = imm_i; m_funct = funct_i;
      m_a1 = rs1_addr_i; m_a2 = rs2_addr_i; m_rd = rd_addr_i;
    end
  endtask

  task automatic set_in(input logic v, input logic [6:0] c, input logic [31:0] d1,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
    valid_i = v; ctrl_i = c; rs1_data_i = d1; rs2_data_i = d1 ^ 32'hA5A5_0000;
    imm_i = ~d1; funct_i = d1[9:0]; rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = rd;
  endtask

  task automatic do_reset();
    stall_i = 0; flush_i = 0;
    #2 rst_i = 0;
    #1 model_clear(1'b0);
    @(posedge clk); #1 rst_i = 1;
  endtask

  task automatic test_reset();
    set_in(1, 7'h7F, 32'hDEAD_BEEF, 5'd3, 5'd4, 5'd5);
    #3;
    n_checks++; if (valid_o !== 1'b0 || ctrl_o !== 7'd0) begin n_fail++;
      $display("FAIL reset_ctrl: got valid=%b ctrl=%h want 0/0", valid_o, ctrl_o); end
    n_checks++; if ({rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !== '0) begin n_fail++;
      $display("FAIL reset_data: got rs1=%h imm=%h rd=%0d want 0", rs1_data_o, imm_o, rd_addr_o); end
    n_checks++; if (bubble_cnt_o !== 16'd0 || hazard_stall_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_cnt: got cnt=%h haz=%b want 0/0", bubble_cnt_o, hazard_stall_o); end
    model_clear(1'b0);
    @(posedge clk); #1 rst_i = 1;
    cycle();  // first edge after release is a normal load
    n_checks++; if (valid_o !== 1'b1 || ctrl_o !== 7'h7F || rs1_data_o !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL first_load: got valid=%b ctrl=%h rs1=%h want 1/7f/deadbeef", valid_o, ctrl_o, rs1_data_o); end
  endtask

  task automatic test_load();
    set_in(1, 7'b1000010, 32'h5, 5'd1, 5'd2, 5'd3);
    cycle();
    n_checks++; if (ctrl_o !== 7'b1000010 || rs1_data_o !== 32'h5 || valid_o !== 1'b1) begin n_fail++;
      $display("FAIL rtype_load: got ctrl=%b rs1=%h valid=%b want 1000010/5/1", ctrl_o, rs1_data_o, valid_o); end
    set_in(0, 7'b1111111, 32'h1234, 5'd7, 5'd8, 5'd9);
    cycle();
    n_checks++; if (valid_o !== 1'b0 || ctrl_o !== 7'd0 || rs1_data_o !== 32'h1234 || rd_addr_o !== 5'd9) begin n_fail++;
      $display("FAIL invalid_load: got valid=%b ctrl=%b rs1=%h rd=%0d want 0/0/1234/9", valid_o, ctrl_o, rs1_data_o, rd_addr_o); end
  endtask

  task automatic test_stall();
    logic [15:0] cnt0;
    set_in(1, 7'b0000011, 32'h77, 5'd10, 5'd11, 5'd12);
    cycle();
    cnt0 = bubble_cnt_o;
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 7'(i + 8), 32'h100 + i, 5'd20, 5'd21, 5'd22);
      cycle();
      n_checks++; if (ctrl_o !== 7'b0000011 || rs1_data_o !== 32'h77 || rd_addr_o !== 5'd12 || bubble_cnt_o !== cnt0) begin n_fail++;
        $display("FAIL stall_hold[%0d]: got ctrl=%b rs1=%h rd=%0d cnt=%h want 0000011/77/12/%h", i, ctrl_o, rs1_data_o, rd_addr_o, bubble_cnt_o, cnt0); end
    end
    stall_i = 0;
    cycle();
    n_checks++; if (ctrl_o !== 7'd10 || rs1_data_o !== 32'h102 || rd_addr_o !== 5'd22) begin n_fail++;
      $display("FAIL stall_release: got ctrl=%h rs1=%h rd=%0d want 0a/102/22", ctrl_o, rs1_data_o, rd_addr_o); end
  endtask

  task automatic test_flush_stall();
    logic [15:0] cnt0;
    cnt0 = bubble_cnt_o;
    set_in(1, 7'b1100010, 32'h99, 5'd1, 5'd2, 5'd3);
    flush_i = 1; stall_i = 1;
    cycle();
    flush_i = 0; stall_i = 0;
    n_checks++; if (valid_o !== 1'b0 || ctrl_o !== 7'd0 || rs1_data_o !== 32'd0 || rd_addr_o !== 5'd0) begin n_fail++;
      $display("FAIL flush_bubble: got valid=%b ctrl=%h rs1=%h rd=%0d want 0/0/0/0", valid_o, ctrl_o, rs1_data_o, rd_addr_o); end
    n_checks++; if (bubble_cnt_o !== cnt0 + 16'd1) begin n_fail++;
      $display("FAIL flush_count: got %h want %h", bubble_cnt_o, cnt0 + 16'd1); end
  endtask

  task automatic test_hazard();
    logic [15:0] cnt0;
    set_in(1, 7'b1110000, 32'h40, 5'd1, 5'd2, 5'd5);  // load into x5
    cycle();
    cnt0 = bubble_cnt_o;
    set_in(1, 7'b1000010, 32'h50, 5'd1, 5'd5, 5'd6);  // consumer of x5 via rs2
    #1;
`ifdef ID_EX_HAZARD_DETECT_EN
    n_checks++; if (hazard_stall_o !== 1'b1) begin n_fail++;
      $display("FAIL hazard_detect: got %b want 1", hazard_stall_o); end
    cycle();
    n_checks++; if (valid_o !== 1'b0 || ctrl_o !== 7'd0 || bubble_cnt_o !== cnt0 + 16'd1) begin n_fail++;
      $display("FAIL hazard_bubble: got valid=%b ctrl=%h cnt=%h want 0/0/%h", valid_o, ctrl_o, bubble_cnt_o, cnt0 + 16'd1); end
`endif
    cycle();  // re-presented instruction now captured
    n_checks++; if (valid_o !== 1'b1 || rs2_addr_o !== 5'd5 || ctrl_o !== 7'b1000010 || bubble_cnt_o !== m_cnt) begin n_fail++;
      $display("FAIL hazard_capture: got valid=%b rs2=%0d ctrl=%b cnt=%h want 1/5/1000010/%h", valid_o, rs2_addr_o, ctrl_o, bubble_cnt_o, m_cnt); end
    set_in(1, 7'b1110000, 32'h60, 5'd1, 5'd2, 5'd0);  // load into x0
    cycle();
    set_in(1, 7'b1000010, 32'h61, 5'd0, 5'd0, 5'd7);
    #1;
    n_checks++; if (hazard_stall_o !== 1'b0) begin n_fail++;
      $display("FAIL hazard_rd0: got %b want 0", hazard_stall_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_i = 1'($urandom); ctrl_i = 7'($urandom);
      rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom; funct_i = 10'($urandom);
      rs1_addr_i = 5'($urandom_range(0, 3)); rs2_addr_i = 5'($urandom_range(0, 3));
      rd_addr_i = 5'($urandom_range(0, 3));
      stall_i = ($urandom_range(0, 99) < 15); flush_i = ($urandom_range(0, 99) < 8);
      #1;
      n_checks++; if (hazard_stall_o !== model_hazard()) begin n_fail++;
        $display("FAIL rand_hazard[%0d]: got %b want %b", i, hazard_stall_o, model_hazard()); end
      cycle();
      n_checks++; if (valid_o !== m_valid || ctrl_o !== m_ctrl || bubble_cnt_o !== m_cnt) begin n_fail++;
        $display("FAIL rand_ctrl[%0d]: got v=%b c=%h cnt=%h want v=%b c=%h cnt=%h", i, valid_o, ctrl_o, bubble_cnt_o, m_valid, m_ctrl, m_cnt); end
      n_checks++; if ({rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !==
                      {m_rs1, m_rs2, m_imm, m_funct, m_a1, m_a2, m_rd}) begin n_fail++;
        $display("FAIL rand_data[%0d]: got rs1=%h rs2=%h imm=%h rd=%0d want rs1=%h rs2=%h imm=%h rd=%0d",
                 i, rs1_data_o, rs2_data_o, imm_o, rd_addr_o, m_rs1, m_rs2, m_imm, m_rd); end
    end
    stall_i = 0; flush_i = 0;
  endtask

  task automatic test_saturation_reset();
    do_reset();
    flush_i = 1;
    for (int i = 0; i < 65534; i++) cycle();
    n_checks++; if (bubble_cnt_o !== 16'hFFFE) begin n_fail++;
      $display("FAIL cnt_fffe: got %h want fffe", bubble_cnt_o); end
    for (int i = 0; i < 3; i++) cycle();
    n_checks++; if (bubble_cnt_o !== 16'hFFFF) begin n_fail++;
      $display("FAIL cnt_saturate: got %h want ffff", bubble_cnt_o); end
    flush_i = 0;
    set_in(1, 7'b1110000, 32'hCAFE, 5'd4, 5'd4, 5'd4);
    cycle();
    stall_i = 1;
    set_in(1, 7'b1000000, 32'h1, 5'd4, 5'd4, 5'd1);
    #2 rst_i = 0;
    #1;
    n_checks++; if (valid_o !== 1'b0 || ctrl_o !== 7'd0 || bubble_cnt_o !== 16'd0 || hazard_stall_o !== 1'b0 ||
                    {rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o} !== '0) begin n_fail++;
      $display("FAIL async_reset: got v=%b c=%h cnt=%h haz=%b rs1=%h want all 0", valid_o, ctrl_o, bubble_cnt_o, hazard_stall_o, rs1_data_o); end
    model_clear(1'b0);
    @(posedge clk); #1 rst_i = 1; stall_i = 0;
    cycle();
    n_checks++; if (valid_o !== 1'b1 || rd_addr_o !== 5'd1 || bubble_cnt_o !== 16'd0) begin n_fail++;
      $display("FAIL post_reset_load: got v=%b rd=%0d cnt=%h want 1/1/0", valid_o, rd_addr_o, bubble_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_hazard();
    test_random();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: valid_i  input  1  ID stage holds a real instruction.
REQ-004 SHALL: stall_i  input  1  external hold; register keeps its contents.
REQ-005 SHALL: flush_i  input  1  kill; insert a bubble on the next edge.
REQ-006 SHALL: ctrl_i  input  7  decoder outputs {RegWrite, MemToReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}.
REQ-007 SHALL: rs1_data_i, rs2_data_i, imm_i  input  32 each  operands and sign-extended immediate.
REQ-008 SHALL: funct_i  input  10  {funct7, funct3} for ALU control.
REQ-009 SHALL: rs1_addr_i, rs2_addr_i, rd_addr_i  input  5 each  register indices.
REQ-010 SHALL: ctrl_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o  output  same widths  registered copies.
REQ-011 SHALL: valid_o  output  1  EX stage holds a real instruction.
REQ-012 SHALL: hazard_stall_o  output  1  load-use stall request to PC and IF/ID.
REQ-013 SHALL: bubble_cnt_o  output  16  count of inserted bubbles.

Function
REQ-014 SHALL: latency is one cycle, from capture of ID inputs to their appearance on the outputs.
REQ-015 SHALL: the per-edge action priority is reset > flush_i > stall_i > hazard bubble > normal load.
REQ-016 SHALL: normal load captures all inputs; valid_o <= valid_i; ctrl_o <= valid_i ? ctrl_i : 0.
REQ-017 SHALL: a bubble sets valid_o=0, ctrl_o=0 and all data/address outputs to 0.
REQ-018 SHALL: under stall_i, every output holds its value, including bubble_cnt_o; hazard_stall_o stays combinational.
REQ-019 SHALL: flush_i and stall_i asserted together produce a flush.
REQ-020 SHALL: bubble_cnt_o increments by 1 on each edge where a flush-bubble or hazard-bubble is inserted, and saturates at 16'hFFFF without wrapping.
REQ-021 SHALL: the register never alters ctrl bits other than forcing them to zero; ALUOp/ALUSrc pass through unmodified.

Reset
REQ-022 SHALL: when rst_i=0, all outputs immediately become 0 (valid_o=0, ctrl_o=0, bubble_cnt_o=0, hazard_stall_o=0), independent of clk_i.
REQ-023 SHALL: reset asserted mid-stall or mid-hazard discards the held instruction.
REQ-024 SHALL: after rst_i deasserts, the first rising edge performs a normal load.

Configuration
REQ-025 SHALL: macro ID_EX_HAZARD_DETECT_EN, when defined, enables load-use detection: hazard_stall_o = valid_o & valid_i & ctrl_o.MemRead & (rd_addr_o != 0) & (rd_addr_o == rs1_addr_i | rd_addr_o == rs2_addr_i).
REQ-026 SHALL: with the macro defined, hazard_stall_o=1 (and no flush_i or stall_i) makes the next edge insert a bubble; the upstream stage holds, so the instruction is re-presented on the following cycle.
REQ-027 SHALL: without the macro, hazard_stall_o is constant 0 and no hazard bubble is ever inserted; bubble_cnt_o counts flushes only.

Verification
REQ-028 SHALL: load valid_i=1, ctrl_i=7'b1000010 (R-type), rs1_data_i=32'h5 -> next cycle ctrl_o=7'b1000010, rs1_data_o=32'h5, valid_o=1.
REQ-029 SHALL: hold stall_i=1 for 3 cycles while the inputs change -> outputs unchanged, then the new values are captured on the first edge after release.
REQ-030 SHALL: flush_i=1 together with stall_i=1 and a valid load -> next cycle valid_o=0, ctrl_o=0, bubble_cnt_o increments by 1.
REQ-031 SHALL: with the macro, a load (MemRead=1, rd=5) in EX and an ID instruction with rs2=5 -> hazard_stall_o=1, one bubble is inserted, and the instruction is captured one cycle later; with rd=0, hazard_stall_o=0.
REQ-032 SHALL: force bubble_cnt_o to 16'hFFFE and apply 3 flushes -> the counter reads 16'hFFFF; asserting rst_i low mid-sequence clears all outputs asynchronously.
